keypad_matrix_scanner: RTL and testbench
========================================

# keypad_matrix_scanner

Input-side counterpart of the multiplexed seven-segment driver. It scans a 4x4 active-low key matrix by driving one row at a time and reading the columns back. A press is accepted only after it is seen identically across several full scans. Each accepted key is delivered as a 4-bit code over a valid/ready handshake to the entry logic that produces the displayed value.

## Interface
- SCAN_DIV_W, 17, row dwell = 2^SCAN_DIV_W clocks; legal ≥ 2
- DEBOUNCE_SCANS, 4, consecutive agreeing full scans needed for press and for release; legal 1..15
- REPEAT_DELAY_SCANS, 32, scans held before first auto-repeat (KEYPAD_AUTOREPEAT_EN only)
- REPEAT_RATE_SCANS, 8, scans between later repeats (KEYPAD_AUTOREPEAT_EN only)
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- row_n  out  4  row drive, active-low, exactly one bit low
- col_n  in  4  column sense, active-low, asynchronous, externally pulled up
- key_code  out  4  row*4 + col of the accepted key
- key_valid  out  1  event pending; held until accepted
- key_ready  in  1  consumer accepts when key_valid && key_ready at a rising edge
- key_held  out  1  debounced key currently down
- key_overrun  out  1  one-clock pulse when an event is dropped

## Operation
- col_n is passed through a 2-flop synchronizer before use.
- A dwell counter of width SCAN_DIV_W + 2 runs freely. Its top 2 bits are the row index r, and row_n = ~(1 << r).
- On the last clock of each dwell, the synchronized columns of row r are written into a 16-bit press map at bits r*4..r*4+3 (bit set = pressed).
- A frame completes at the end of the row-3 dwell. The frame is classified as NONE (0 bits set), SINGLE(k) (exactly 1 bit set, code k), or MULTI (more than 1 bit set).
- FSM states, evaluated once per frame:
  - IDLE: SINGLE(k) → DEBOUNCE, with cand=k and cnt=1. If DEBOUNCE_SCANS=1, go straight to PRESSED and emit. Any other frame stays in IDLE.
  - DEBOUNCE: SINGLE(cand) → cnt+1; when cnt reaches DEBOUNCE_SCANS, emit cand and go to PRESSED. NONE, MULTI or a different key → IDLE with cnt=0.
  - PRESSED: key_held=1. SINGLE(cand) sets rel=0. Any other frame increments rel; when rel reaches DEBOUNCE_SCANS → IDLE with key_held=0.
- Emit: if key_valid=0, or it is being accepted in the same clock, load key_code and set key_valid=1. Otherwise drop the event, keep key_code unchanged and pulse key_overrun.
- key_valid clears on acceptance unless a new emit occurs in the same clock.
- A new key can only be accepted after the release of the previous one.

## Timing
- Reset values: row_n=4'b1110, key_code=0, key_valid=0, key_held=0, key_overrun=0, FSM=IDLE, all counters and the press map 0.
- Scan period is 4*2^SCAN_DIV_W clocks.
- key_valid and key_held rise 1 clock after the end-of-frame sample that completes the debounce.
- Column latency: column changes are seen 2 clocks after arrival.
- A column edge inside the final 2 clocks of a dwell may be missed; debounce absorbs this.
- Asserting reset mid-press returns everything to reset values. A key still held after reset is treated as a new press and takes DEBOUNCE_SCANS scans.
- key_overrun is high for exactly one clock per dropped event.

## Configuration
- KEYPAD_AUTOREPEAT_EN defined:
  - In PRESSED, a scan counter emits cand again after REPEAT_DELAY_SCANS scans, then every REPEAT_RATE_SCANS scans, while the frame remains SINGLE(cand).
  - Repeats follow the same overrun rule as normal emits.
- Undefined: exactly one event per press; the repeat counters are not built.

## Structure
- keypad_pkg holds the FSM state enum (IDLE, DEBOUNCE, PRESSED), the frame class enum (NONE, SINGLE, MULTI), ROWS=4 and COLS=4.
- One sub-module, keypad_frame_classifier: purely combinational, 16-bit map → class + 4-bit code.
- The top level holds the synchronizer, scan counter, FSM, and output register.

## Test plan
All scenarios use SCAN_DIV_W=2 and DEBOUNCE_SCANS=2, giving a 16-clock scan.
- Reset asserted then released, no keys pressed → row_n cycles 1110, 1101, 1011, 0111 every 4 clocks; all outputs stay 0.
- Key row2/col1 held, key_ready=1 → after 2 frames key_valid=1 with key_code=9; valid clears the next clock; exactly one event; key_held falls 2 frames after release.
- Key row0/col2 held for 1 frame only, or row0/col0 and row1/col3 held together → no event, key_held stays 0.
- key_ready=0; press and release 5, then press 6 → key_code stays 5, key_overrun pulses once; raising key_ready then clears key_valid.
- Reset pulsed while key 9 is in PRESSED with key_valid=1 → all outputs 0 immediately; with the key still held, the event re-emits 2 frames after reset is released.
- With KEYPAD_AUTOREPEAT_EN, REPEAT_DELAY_SCANS=4 and REPEAT_RATE_SCANS=2, key 3 held → events at frames 2, 6, 8, 10 and so on. Without the macro → only the frame-2 event.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad matrix scanner.
// Holds the FSM state enum, the frame class enum and the matrix size.
package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED
  } state_e;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } frame_e;

endpackage

// File: rtl/keypad_frame_classifier.sv
// Classifies one full-scan press map as no key, a single key, or several keys.
// Ports: map_i (16-bit press map, bit set = pressed), cls_o (frame class),
// code_o (index of the pressed key; valid when cls_o is SINGLE).
module keypad_frame_classifier
  import keypad_pkg::*;
(
  input  logic [ROWS*COLS-1:0] map_i,
  output frame_e               cls_o,
  output logic [3:0]           code_o
);

  always_comb begin
    cls_o  = NONE;
    code_o = 4'd0;
    for (int i = 0; i < ROWS*COLS; i++) begin
      if (map_i[i]) begin
        if (cls_o == NONE) begin
          cls_o  = SINGLE;
          code_o = 4'(i);
        end else begin
          cls_o = MULTI;
        end
      end
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Scans a 4x4 active-low key matrix, debounces over full scans and hands
// accepted key codes out over a valid/ready handshake.
// Ports: clk, reset (async, active-high), row_n (row drive, one bit low),
// col_n (column sense, async), key_code/key_valid/key_ready (event
// handshake), key_held (debounced key down), key_overrun (dropped event).
// Option: define KEYPAD_AUTOREPEAT_EN to add auto-repeat while a key is held.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV_W         = 17,
  parameter int DEBOUNCE_SCANS     = 4
`ifdef KEYPAD_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY_SCANS = 32,
  parameter int REPEAT_RATE_SCANS  = 8
`endif
) (
  input  logic            clk,
  input  logic            reset,
  output logic [ROWS-1:0] row_n,
  input  logic [COLS-1:0] col_n,
  output logic [3:0]      key_code,
  output logic            key_valid,
  input  logic            key_ready,
  output logic            key_held,
  output logic            key_overrun
);

  localparam int DW = SCAN_DIV_W + 2;
  localparam logic [3:0] DB_N = 4'(DEBOUNCE_SCANS);

  logic [COLS-1:0] sync1_q, sync2_q;
  logic [DW-1:0] div_q, div_d;
  logic [ROWS*COLS-1:0] map_q, map_d;
  state_e state_q, state_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] rel_q, rel_d;
  logic [3:0] code_q, code_d;
  logic valid_q, valid_d;
  logic ovr_q, ovr_d;

  logic [1:0] row;
  logic dwell_end, frame_end;
  logic match, emit;
  frame_e cls;
  logic [3:0] cls_code;

  assign row       = div_q[DW-1 -: 2];
  assign dwell_end = &div_q[SCAN_DIV_W-1:0];
  assign frame_end = dwell_end && (row == 2'd3);
  assign div_d     = div_q + 1'b1;
  assign row_n     = ~(4'b0001 << row);

  // The row being closed out is merged in here so the frame-end
  // classification already sees the row-3 sample.
  always_comb begin
    map_d = map_q;
    if (dwell_end) begin
      map_d[{row, 2'b00} +: COLS] = ~sync2_q;
    end
  end

  keypad_frame_classifier u_cls (
    .map_i  (map_d),
    .cls_o  (cls),
    .code_o (cls_code)
  );

  assign match = (cls == SINGLE) && (cls_code == cand_q);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [7:0] RD_N = 8'(REPEAT_DELAY_SCANS);
  localparam logic [7:0] RR_N = 8'(REPEAT_RATE_SCANS);
  logic [7:0] rpt_q, rpt_d;
  logic first_q, first_d;
`endif

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    emit    = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rpt_d   = rpt_q;
    first_d = first_q;
    if (state_q != PRESSED) begin
      rpt_d   = 8'd0;
      first_d = 1'b1;
    end
`endif
    if (frame_end) begin
      unique case (state_q)
        IDLE: begin
          if (cls == SINGLE) begin
            cand_d = cls_code;
            if (DB_N == 4'd1) begin
              state_d = PRESSED;
              rel_d   = 4'd0;
              cnt_d   = 4'd0;
              emit    = 1'b1;
            end else begin
              state_d = DEBOUNCE;
              cnt_d   = 4'd1;
            end
          end
        end
        DEBOUNCE: begin
          if (match) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == DB_N) begin
              state_d = PRESSED;
              rel_d   = 4'd0;
              cnt_d   = 4'd0;
              emit    = 1'b1;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end
        end
        PRESSED: begin
          if (match) begin
            rel_d = 4'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_d = rpt_q + 8'd1;
            if (rpt_q + 8'd1 == (first_q ? RD_N : RR_N)) begin
              rpt_d   = 8'd0;
              first_d = 1'b0;
              emit    = 1'b1;
            end
`endif
          end else begin
            rel_d = rel_q + 4'd1;
            if (rel_q + 4'd1 == DB_N) begin
              state_d = IDLE;
              rel_d   = 4'd0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A fresh emit wins over acceptance; an emit against a stalled
  // consumer is dropped and flagged instead of overwriting the code.
  always_comb begin
    code_d  = code_q;
    valid_d = valid_q && !key_ready;
    ovr_d   = 1'b0;
    if (emit) begin
      if (!valid_q || key_ready) begin
        code_d  = cand_d;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      div_q   <= '0;
      map_q   <= '0;
      state_q <= IDLE;
      cand_q  <= 4'd0;
      cnt_q   <= 4'd0;
      rel_q   <= 4'd0;
      code_q  <= 4'd0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_q   <= 8'd0;
      first_q <= 1'b1;
`endif
    end else begin
      sync1_q <= col_n;
      sync2_q <= sync1_q;
      div_q   <= div_d;
      map_q   <= map_d;
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_q   <= rpt_d;
      first_q <= first_d;
`endif
    end
  end

  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign key_held    = (state_q == PRESSED);
  assign key_overrun = ovr_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner with a 16-clock scan and
// two-scan debounce; a behavioural key matrix drives col_n from row_n.
`timescale 1ns/1ps
module tb_keypad_matrix_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_held;
  logic       key_overrun;
  logic [15:0] keys;

  int checks = 0;
  int errors = 0;
  int ev_cnt = 0;
  int ovr_cnt = 0;
  int e0, o0;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam bit RPT = 1'b1;
`else
  localparam bit RPT = 1'b0;
`endif

  always #5 clk = ~clk;

  keypad_matrix_scanner #(
    .SCAN_DIV_W         (2),
    .DEBOUNCE_SCANS     (2)
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY_SCANS (4),
    .REPEAT_RATE_SCANS  (2)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .row_n       (row_n),
    .col_n       (col_n),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_held    (key_held),
    .key_overrun (key_overrun)
  );

  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
  end

  always @(posedge clk) begin
    if (key_valid && key_ready) ev_cnt++;
    if (key_overrun) ovr_cnt++;
  end

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    key_ready = 1'b1;
    keys = 16'h0000;
    @(negedge clk);
    chk("rst_row", 16'(row_n), 16'hE);
    chk("rst_code", 16'(key_code), 16'h0);
    chk("rst_valid", 16'(key_valid), 16'h0);
    chk("rst_held", 16'(key_held), 16'h0);
    chk("rst_ovr", 16'(key_overrun), 16'h0);

    // idle scan
    do_reset();
    chk("row0", 16'(row_n), 16'hE);
    step(4);
    chk("row1", 16'(row_n), 16'hD);
    step(4);
    chk("row2", 16'(row_n), 16'hB);
    step(4);
    chk("row3", 16'(row_n), 16'h7);
    step(4);
    chk("row0b", 16'(row_n), 16'hE);
    chk("idle_out", 16'({key_valid, key_held, key_overrun}), 16'h0);

    // key 9 press, accept, release
    keys = 16'h0200;
    do_reset();
    e0 = ev_cnt;
    step(31);
    chk("k9_pre", 16'(key_valid), 16'h0);
    step(1);
    chk("k9_valid", 16'(key_valid), 16'h1);
    chk("k9_code", 16'(key_code), 16'h9);
    chk("k9_held", 16'(key_held), 16'h1);
    step(1);
    chk("k9_clr", 16'(key_valid), 16'h0);
    keys = 16'h0000;
    step(30);
    chk("k9_held_rel", 16'(key_held), 16'h1);
    step(1);
    chk("k9_held_fall", 16'(key_held), 16'h0);
    step(32);
    chk("k9_events", 16'(ev_cnt - e0), 16'd1);

    // one-frame glitch on key 2
    keys = 16'h0004;
    do_reset();
    e0 = ev_cnt;
    step(16);
    keys = 16'h0000;
    step(48);
    chk("glitch_out", 16'({key_valid, key_held}), 16'h0);
    chk("glitch_ev", 16'(ev_cnt - e0), 16'd0);

    // two keys at once
    keys = 16'h0081;
    do_reset();
    e0 = ev_cnt;
    step(64);
    chk("multi_out", 16'({key_valid, key_held}), 16'h0);
    chk("multi_ev", 16'(ev_cnt - e0), 16'd0);

    // overrun with stalled consumer
    key_ready = 1'b0;
    keys = 16'h0020;
    do_reset();
    e0 = ev_cnt;
    o0 = ovr_cnt;
    step(32);
    chk("k5_valid", 16'(key_valid), 16'h1);
    chk("k5_code", 16'(key_code), 16'h5);
    step(1);
    keys = 16'h0000;
    step(31);
    chk("k5_rel", 16'(key_held), 16'h0);
    keys = 16'h0040;
    step(31);
    chk("ovr_pre", 16'(key_overrun), 16'h0);
    step(1);
    chk("ovr_pulse", 16'(key_overrun), 16'h1);
    chk("ovr_code", 16'(key_code), 16'h5);
    chk("ovr_valid", 16'(key_valid), 16'h1);
    chk("ovr_held", 16'(key_held), 16'h1);
    step(1);
    chk("ovr_end", 16'(key_overrun), 16'h0);
    key_ready = 1'b1;
    step(1);
    chk("ovr_acc", 16'(key_valid), 16'h0);
    chk("ovr_cnt", 16'(ovr_cnt - o0), 16'd1);
    chk("ovr_ev", 16'(ev_cnt - e0), 16'd1);

    // reset while pressed with a pending event
    key_ready = 1'b0;
    keys = 16'h0200;
    do_reset();
    step(32);
    chk("mid_valid", 16'({key_valid, key_held}), 16'h3);
    step(1);
    reset = 1'b1;
    #1;
    chk("mid_rst_out", 16'({key_valid, key_held, key_overrun}), 16'h0);
    chk("mid_rst_code", 16'(key_code), 16'h0);
    chk("mid_rst_row", 16'(row_n), 16'hE);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    step(31);
    chk("re_pre", 16'(key_valid), 16'h0);
    step(1);
    chk("re_valid", 16'(key_valid), 16'h1);
    chk("re_code", 16'(key_code), 16'h9);

    // long hold on key 3
    key_ready = 1'b1;
    keys = 16'h0008;
    do_reset();
    e0 = ev_cnt;
    step(32);
    chk("k3_f2", 16'(key_valid), 16'h1);
    chk("k3_code", 16'(key_code), 16'h3);
    step(64);
    chk("k3_f6", 16'(key_valid), 16'(RPT));
    step(16);
    chk("k3_f7", 16'(key_valid), 16'h0);
    step(16);
    chk("k3_f8", 16'(key_valid), 16'(RPT));
    step(32);
    chk("k3_f10", 16'(key_valid), 16'(RPT));
    step(10);
    chk("k3_ev", 16'(ev_cnt - e0), RPT ? 16'd4 : 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
